// File: rtl/next_pc_ctrl.sv
// next_pc_ctrl
//   Multi-cycle instruction sequencer (IF -> ID -> EX -> MEM -> WB, plus HALT)
//   that supplies the next value of an always-loading PC register. On every
//   cycle that must not advance the PC it returns the current addr, so the
//   PC register itself needs no enable.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset (PC loads 0, state -> IF)
//   addr         current PC from the PC register
//   next_addr    value the PC register loads at the next edge (combinational)
//   opcode       IR opcode field, stable from ID to the end of the instruction
//   zero         ALU zero flag, used by beq in EX
//   branch_off   two's-complement word offset for beq
//   jump_target  absolute word target for j
//   mem_ready    memory completion handshake, sampled in IF and MEM only
//   state        current state encoding (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   ir_write     instruction register load strobe
//   mem_read     memory read request
//   mem_write    memory write request
//   reg_write    register file write strobe
//   halted       high while in HALT
module next_pc_ctrl #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] next_addr,
  input  logic [5:0]    opcode,
  input  logic          zero,
  input  logic [AW-1:0] branch_off,
  input  logic [AW-1:0] jump_target,
  input  logic          mem_ready,
  output logic [2:0]    state,
  output logic          ir_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic          reg_write,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t nxt_state;

  // The state register is kept as a raw 3-bit vector so the unused codes
  // 6 and 7 remain representable and are steered back to IF.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IF;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_IF;
    next_addr = addr;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    halted    = 1'b0;

    if (rst) begin
      // Force the PC to 0 and suppress every strobe, whatever the state.
      next_addr = '0;
    end else begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            next_addr = addr + AW'(1);
            nxt_state = S_ID;
          end else begin
            nxt_state = S_IF;
          end
        end

        S_ID: begin
          case (opcode)
            OP_J: begin
              next_addr = jump_target;
              nxt_state = S_IF;
            end
            OP_HALT:                         nxt_state = S_HALT;
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ:  nxt_state = S_EX;
            default:                         nxt_state = S_IF;
          endcase
        end

        S_EX: begin
          case (opcode)
            OP_BEQ: begin
              // addr already holds PC+1 here, so the offset is relative to it.
              if (zero) next_addr = addr + branch_off;
              nxt_state = S_IF;
            end
            OP_RTYPE:     nxt_state = S_WB;
            OP_LW, OP_SW: nxt_state = S_MEM;
            default:      nxt_state = S_IF;
          endcase
        end

        S_MEM: begin
          case (opcode)
            OP_LW: begin
              mem_read  = 1'b1;
              nxt_state = mem_ready ? S_WB : S_MEM;
            end
            OP_SW: begin
              mem_write = 1'b1;
              nxt_state = mem_ready ? S_IF : S_MEM;
            end
            default: nxt_state = S_IF;
          endcase
        end

        S_WB: begin
          reg_write = 1'b1;
          nxt_state = S_IF;
        end

        S_HALT: begin
          halted    = 1'b1;
          nxt_state = S_HALT;
        end

        default: nxt_state = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Bench for next_pc_ctrl. A behavioural PC register closes the loop
// (pc <= next_addr every edge, with a side door to preload a PC value while
// the sequencer idles in IF). Each scenario pushes per-cycle expectations
// (inputs to drive plus expected pc/state/next_addr/strobes) into a queue,
// then pops them one cycle at a time and compares.
module tb_next_pc_ctrl;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [AW-1:0] next_addr;
  logic [5:0]    opcode;
  logic          zero;
  logic [AW-1:0] branch_off;
  logic [AW-1:0] jump_target;
  logic          mem_ready;
  logic [2:0]    state;
  logic          ir_write, mem_read, mem_write, reg_write, halted;

  logic [AW-1:0] pc;
  logic          pc_set_en;
  logic [AW-1:0] pc_set_val;

  always #5 clk = ~clk;

  assign addr = pc;
  always @(posedge clk) pc <= pc_set_en ? pc_set_val : next_addr;

  next_pc_ctrl #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .next_addr   (next_addr),
    .opcode      (opcode),
    .zero        (zero),
    .branch_off  (branch_off),
    .jump_target (jump_target),
    .mem_ready   (mem_ready),
    .state       (state),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .halted      (halted)
  );

  // Strobe vector order: {ir_write, mem_read, mem_write, reg_write, halted}
  localparam logic [4:0] SB_NONE  = 5'b00000;
  localparam logic [4:0] SB_FETCH = 5'b11000;
  localparam logic [4:0] SB_MR    = 5'b01000;
  localparam logic [4:0] SB_MW    = 5'b00100;
  localparam logic [4:0] SB_RW    = 5'b00010;
  localparam logic [4:0] SB_H     = 5'b00001;

  localparam int IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4, HALT = 5;

  typedef struct packed {
    logic          r;
    logic          m;
    logic          z;
    logic [AW-1:0] pc;
    logic [2:0]    st;
    logic [AW-1:0] na;
    logic [4:0]    sb;
  } step_t;

  step_t q[$];
  int tests  = 0;
  int failed = 0;

  function automatic void push(input logic r, input logic m, input logic z,
                               input int p, input int s, input int n,
                               input logic [4:0] sb);
    step_t e;
    e.r  = r;
    e.m  = m;
    e.z  = z;
    e.pc = AW'(p);
    e.st = 3'(s);
    e.na = AW'(n);
    e.sb = sb;
    q.push_back(e);
  endfunction

  // Drive one cycle's inputs, sample outputs mid-cycle, then move past the edge.
  task automatic apply(input step_t e, output step_t got);
    rst       = e.r;
    mem_ready = e.m;
    zero      = e.z;
    #1;
    got.r  = e.r;
    got.m  = e.m;
    got.z  = e.z;
    got.pc = addr;
    got.st = state;
    got.na = next_addr;
    got.sb = {ir_write, mem_read, mem_write, reg_write, halted};
    @(posedge clk);
    #1;
  endtask

  // Preload the PC while the sequencer waits in IF (mem_ready low).
  task automatic set_pc(input int v);
    rst        = 1'b0;
    mem_ready  = 1'b0;
    pc_set_en  = 1'b1;
    pc_set_val = AW'(v);
    @(posedge clk);
    #1;
    pc_set_en  = 1'b0;
  endtask

  task automatic test_reset;
    step_t e, got;
    int k = 0;
    opcode = 6'b000000;
    push(1, 1, 0, 0, IF, 0, SB_NONE);
    push(0, 1, 0, 0, IF, 1, SB_FETCH);
    push(0, 1, 0, 1, ID, 1, SB_NONE);
    push(0, 1, 0, 1, EX, 1, SB_NONE);
    push(0, 1, 0, 1, WB, 1, SB_RW);
    push(0, 0, 0, 1, IF, 1, SB_MR);
    while (q.size() != 0) begin
      e = q.pop_front();
      apply(e, got);
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL reset_rtype step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                 k, got.pc, got.st, got.na, got.sb, e.pc, e.st, e.na, e.sb);
      end
      k++;
    end
  endtask

  task automatic test_stall;
    step_t e, got;
    int k = 0;
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) push(0, 0, 0, 1, IF, 1, SB_MR);
    push(0, 1, 0, 1, IF, 2, SB_FETCH);
    push(0, 1, 0, 2, ID, 2, SB_NONE);
    push(0, 1, 0, 2, EX, 2, SB_NONE);
    push(0, 1, 0, 2, MEM, 2, SB_MR);
    push(0, 1, 0, 2, WB, 2, SB_RW);
    // Second lw stalls in MEM; mem_ready low in ID/EX/WB must be ignored.
    push(0, 1, 0, 2, IF, 3, SB_FETCH);
    push(0, 0, 0, 3, ID, 3, SB_NONE);
    push(0, 0, 0, 3, EX, 3, SB_NONE);
    for (int i = 0; i < 3; i++) push(0, 0, 0, 3, MEM, 3, SB_MR);
    push(0, 1, 0, 3, MEM, 3, SB_MR);
    push(0, 0, 0, 3, WB, 3, SB_RW);
    push(0, 0, 0, 3, IF, 3, SB_MR);
    while (q.size() != 0) begin
      e = q.pop_front();
      apply(e, got);
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL stall_lw step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                 k, got.pc, got.st, got.na, got.sb, e.pc, e.st, e.na, e.sb);
      end
      k++;
    end
  endtask

  task automatic test_beq;
    step_t e, got;
    int k = 0;
    opcode     = 6'b000100;
    branch_off = 6'b111101;
    for (int pass = 0; pass < 2; pass++) begin
      set_pc(9);
      push(0, 1, 0, 9, IF, 10, SB_FETCH);
      if (pass == 0) begin
        push(0, 1, 0, 10, ID, 10, SB_NONE);
        push(0, 1, 1, 10, EX, 7, SB_NONE);
        push(0, 0, 0, 7, IF, 7, SB_MR);
      end else begin
        // zero high outside EX must not matter
        push(0, 1, 1, 10, ID, 10, SB_NONE);
        push(0, 1, 0, 10, EX, 10, SB_NONE);
        push(0, 0, 1, 10, IF, 10, SB_MR);
      end
      while (q.size() != 0) begin
        e = q.pop_front();
        apply(e, got);
        tests++;
        if (got !== e) begin
          failed++;
          $display("FAIL beq_%s step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                   pass == 0 ? "taken" : "not_taken", k, got.pc, got.st, got.na, got.sb,
                   e.pc, e.st, e.na, e.sb);
        end
        k++;
      end
    end
  endtask

  task automatic test_jump_wrap;
    step_t e, got;
    int k = 0;
    opcode      = 6'b000010;
    jump_target = 6'd42;
    push(0, 1, 0, 10, IF, 11, SB_FETCH);
    push(0, 1, 0, 11, ID, 42, SB_NONE);
    push(0, 0, 0, 42, IF, 42, SB_MR);
    while (q.size() != 0) begin
      e = q.pop_front();
      apply(e, got);
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL jump step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                 k, got.pc, got.st, got.na, got.sb, e.pc, e.st, e.na, e.sb);
      end
      k++;
    end
    set_pc(63);
    opcode = 6'b010101;
    push(0, 1, 0, 63, IF, 0, SB_FETCH);
    push(0, 1, 0, 0, ID, 0, SB_NONE);
    push(0, 0, 0, 0, IF, 0, SB_MR);
    while (q.size() != 0) begin
      e = q.pop_front();
      apply(e, got);
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL wrap_nop step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                 k, got.pc, got.st, got.na, got.sb, e.pc, e.st, e.na, e.sb);
      end
      k++;
    end
  endtask

  task automatic test_halt;
    step_t e, got;
    int k = 0;
    set_pc(5);
    opcode = 6'b111111;
    push(0, 1, 0, 5, IF, 6, SB_FETCH);
    push(0, 1, 0, 6, ID, 6, SB_NONE);
    for (int i = 0; i < 20; i++) push(0, 1'(i), 0, 6, HALT, 6, SB_H);
    push(1, 1, 0, 6, HALT, 0, SB_NONE);
    push(0, 0, 0, 0, IF, 0, SB_MR);
    while (q.size() != 0) begin
      e = q.pop_front();
      apply(e, got);
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL halt step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                 k, got.pc, got.st, got.na, got.sb, e.pc, e.st, e.na, e.sb);
      end
      k++;
    end
  endtask

  task automatic test_mid_reset_illegal;
    step_t e, got;
    int k = 0;
    opcode = 6'b101011;
    push(0, 1, 0, 0, IF, 1, SB_FETCH);
    push(0, 1, 0, 1, ID, 1, SB_NONE);
    push(0, 1, 0, 1, EX, 1, SB_NONE);
    push(0, 1, 0, 1, MEM, 1, SB_MW);
    push(0, 1, 0, 1, IF, 2, SB_FETCH);
    push(0, 1, 0, 2, ID, 2, SB_NONE);
    push(0, 1, 0, 2, EX, 2, SB_NONE);
    push(0, 0, 0, 2, MEM, 2, SB_MW);
    push(1, 0, 0, 2, MEM, 0, SB_NONE);
    push(0, 0, 0, 0, IF, 0, SB_MR);
    while (q.size() != 0) begin
      e = q.pop_front();
      apply(e, got);
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL mid_reset step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                 k, got.pc, got.st, got.na, got.sb, e.pc, e.st, e.na, e.sb);
      end
      k++;
    end

    // Illegal code 6: outputs idle, then IF on the following edge.
    push(0, 0, 0, 0, 6, 0, SB_NONE);
    push(0, 0, 0, 0, IF, 0, SB_MR);
    rst       = 1'b0;
    mem_ready = 1'b0;
    force dut.state = 3'd6;
    #1;
    release dut.state;
    k = 0;
    while (q.size() != 0) begin
      e = q.pop_front();
      apply(e, got);
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL illegal_state step %0d: got pc=%0d st=%0d na=%0d sb=%b, want pc=%0d st=%0d na=%0d sb=%b",
                 k, got.pc, got.st, got.na, got.sb, e.pc, e.st, e.na, e.sb);
      end
      k++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    mem_ready   = 1'b0;
    zero        = 1'b0;
    opcode      = '0;
    branch_off  = '0;
    jump_target = '0;
    pc_set_en   = 1'b0;
    pc_set_val  = '0;
    @(posedge clk);
    #1;
    test_reset;
    test_stall;
    test_beq;
    test_jump_wrap;
    test_halt;
    test_mid_reset_illegal;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/next_pc_ctrl.md
# next_pc_ctrl

Multi-cycle sequencer that drives the `next_addr` input of the program-counter register and steps each instruction through fetch, decode, execute, memory and write-back. The PC register loads `next_addr` on every rising edge with no enable, so this block holds it by returning the current `addr` on every cycle that must not advance the PC. It also issues the per-state strobes for instruction-register load, memory access and register write-back.

## Interface
Parameters:
- `AW`, 6: PC / word-address width; all PC arithmetic is modulo 2^AW.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  AW  current PC value, from the PC register output.
- `next_addr`  out  AW  value the PC register loads at the next edge. Combinational from state and inputs.
- `opcode`  in  6  instruction-register opcode field. Valid from ID onward.
- `zero`  in  1  ALU zero flag. Sampled in EX for beq.
- `branch_off`  in  AW  two's-complement word offset for beq.
- `jump_target`  in  AW  absolute word target for j.
- `mem_ready`  in  1  memory completion handshake for IF and MEM.
- `state`  out  3  current state encoding.
- `ir_write`  out  1  load the instruction register.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register-file write strobe.
- `halted`  out  1  high while in HALT.

## Operation
States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to IF on the next edge.

Opcodes:
- R-type = 000000
- lw = 100011
- sw = 101011
- beq = 000100
- j = 000010
- halt = 111111
- Any other opcode is a NOP.

Per-state behaviour:
- **IF**: `mem_read`=1.
  - If `mem_ready`=1: `ir_write`=1, `next_addr`=`addr`+1, go to ID.
  - Otherwise: `next_addr`=`addr`, stay in IF.
- **ID**: decode `opcode`.
  - j: `next_addr`=`jump_target`, go to IF.
  - halt: go to HALT.
  - NOP: go to IF.
  - R-type, lw, sw, beq: go to EX.
  - `next_addr`=`addr` in every case except j.
- **EX**:
  - beq: `next_addr`=`addr`+`branch_off` if `zero`=1, else `addr`; go to IF.
  - R-type: go to WB.
  - lw, sw: go to MEM.
  - For beq, `addr` already holds the incremented PC.
- **MEM**:
  - lw: `mem_read`=1. On `mem_ready`=1, go to WB.
  - sw: `mem_write`=1. On `mem_ready`=1, go to IF.
  - Without `mem_ready`, stay in MEM.
  - `next_addr`=`addr`.
- **WB**: `reg_write`=1, `next_addr`=`addr`, go to IF.
- **HALT**: `halted`=1, `next_addr`=`addr`, stay in HALT until `rst`.

Rules:
- All strobes are 0 except where listed above.
- `opcode` is held stable by the IR from ID through the end of the instruction. The block does not latch it.
- PC arithmetic is AW-bit modulo:
  - 63+1 → 0.
  - `branch_off` is sign-interpreted: 0 + 111111 → 63.

## Timing
- **Reset**: while `rst`=1:
  - `next_addr`=0, so the PC loads 0 at that edge.
  - All strobes and `halted` are 0.
  - `state` becomes IF at the edge.
- Reset takes priority in every state, including HALT and any mid-instruction state with `mem_ready` pending. No partial strobe may be issued while `rst`=1.
- **Latencies** (cycles from the IF entry edge back to IF, with `mem_ready` tied to 1):
  - NOP: 2
  - j: 2
  - beq: 3
  - R-type: 4
  - sw: 4
  - lw: 5
  - Each low-`mem_ready` cycle in IF or MEM adds exactly one cycle.
- `mem_ready` is sampled only in IF and MEM. It is ignored in all other states.
- PC update points:
  - Increment happens exactly at the IF→ID edge.
  - Jump and branch targets appear exactly at the ID→IF edge (j) or the EX→IF edge (beq).
  - No other edge changes the PC.

## Test plan
- **Reset and sequential fetch.** Stimulus: `rst` for 2 cycles, `mem_ready`=1, opcode R-type. Required: PC goes 0 → 1 at the first IF→ID edge; `reg_write` pulses in cycle 4; PC=1 on return to IF.
- **Memory stall.** Stimulus: IF with `mem_ready`=0 for 3 cycles, then 1. Required: `next_addr`=`addr` for 3 cycles, `ir_write` only in cycle 4; lw in MEM with the same stall completes in 8 cycles total.
- **beq.** Stimulus: taken (PC=10 after IF, `branch_off`=111101, `zero`=1), then not taken (`zero`=0). Required: taken gives PC=7; not taken gives PC=10.
- **j.** Stimulus: `jump_target`=42. Required: PC=42 after 2 cycles. Wrap: PC=63 with NOP gives PC=0.
- **Halt.** Stimulus: halt opcode at PC=5. Required: `halted`=1, PC frozen at 6 for 20 cycles; `rst` returns to PC=0 in IF with `halted`=0.
- **Mid-operation reset and illegal state.** Stimulus: reset asserted in MEM with `mem_ready`=0 (sw); then force `state`=6 via the bench. Required: after reset, no `mem_write`, PC=0, state=IF; the forced illegal state recovers to IF on the next edge.
